// File: rtl/lcd_bus_scheduler.sv
// Two-port arbiter for the 8080-style LCD write bus: power-up hold-off, fixed priority
// at transaction boundaries, and wr strobe generation with programmable low/high widths.
module lcd_bus_scheduler #(
  parameter int WR_LOW    = 2,
  parameter int WR_HIGH   = 2,
  parameter int BOOT_WAIT = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_dcx,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_dcx,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       wr,
  output logic       dcx,
  output logic [7:0] D,
  output logic [1:0] grant,
  output logic       busy,
  output logic       boot_done
);

  localparam int PH_MAX = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BT_W   = $clog2(BOOT_WAIT + 1);
  localparam logic [PH_W-1:0] LOW_END  = PH_W'(WR_LOW - 1);
  localparam logic [PH_W-1:0] HIGH_END = PH_W'(WR_HIGH - 1);
  localparam logic [BT_W-1:0] BOOT_END = BT_W'(BOOT_WAIT - 1);

  typedef enum logic [1:0] {BOOT, IDLE, LOW, HIGH} state_t;

  state_t          state_reg;
  logic [PH_W-1:0] phase_reg;
  logic [BT_W-1:0] boot_cnt_reg;
  logic            wr_reg;
  logic            dcx_reg;
  logic [7:0]      d_reg;
  logic [1:0]      grant_reg;
  logic            lock_reg;
  logic            last_reg;
  logic            boot_done_reg;

  logic [1:0]      valid_vec;
  logic [1:0]      dcx_vec;
  logic [1:0]      last_vec;
  logic [1:0][7:0] data_vec;
  logic [1:0]      sel;
  logic [1:0]      ready_vec;
  logic            acc_port;

  assign valid_vec = {req1_valid, req0_valid};
  assign dcx_vec   = {req1_dcx, req0_dcx};
  assign last_vec  = {req1_last, req0_last};
  assign data_vec  = {req1_data, req0_data};

  // While locked the owner is the only candidate, even if port 0 is waiting.
  assign sel[0] = lock_reg ? grant_reg[0] : valid_vec[0];
  assign sel[1] = lock_reg ? grant_reg[1] : (valid_vec[1] && !valid_vec[0]);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == IDLE) && sel[gi] && valid_vec[gi];
    end
  endgenerate

  assign acc_port   = ready_vec[1];
  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg     <= BOOT;
      phase_reg     <= '0;
      boot_cnt_reg  <= '0;
      wr_reg        <= 1'b1;
      dcx_reg       <= 1'b1;
      d_reg         <= 8'h00;
      grant_reg     <= 2'b00;
      lock_reg      <= 1'b0;
      last_reg      <= 1'b0;
      boot_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          if (boot_cnt_reg == BOOT_END) begin
            state_reg     <= IDLE;
            boot_done_reg <= 1'b1;
          end else begin
            boot_cnt_reg <= boot_cnt_reg + 1'b1;
          end
        end
        IDLE: begin
          if (|ready_vec) begin
            d_reg     <= data_vec[acc_port];
            dcx_reg   <= dcx_vec[acc_port];
            grant_reg <= ready_vec;
            lock_reg  <= ~last_vec[acc_port];
            last_reg  <= last_vec[acc_port];
            wr_reg    <= 1'b0;
            phase_reg <= '0;
            state_reg <= LOW;
          end
        end
        LOW: begin
          if (phase_reg == LOW_END) begin
            wr_reg    <= 1'b1;
            phase_reg <= '0;
            state_reg <= HIGH;
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end
        HIGH: begin
          // D/dcx stay put through the high phase to give the panel its hold time.
          if (phase_reg == HIGH_END) begin
            state_reg <= IDLE;
            if (last_reg) grant_reg <= 2'b00;
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

  assign wr        = wr_reg;
  assign dcx       = dcx_reg;
  assign D         = d_reg;
  assign grant     = grant_reg;
  assign busy      = (state_reg != IDLE) || lock_reg;
  assign boot_done = boot_done_reg;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Bench for lcd_bus_scheduler: two instances (default and 1/1 strobe widths) share one
// stimulus stream and are checked every cycle against a countdown-based behavioural model.
module tb_lcd_bus_scheduler;

  localparam int BW = 16;
  int wl [2] = '{2, 1};
  int wh [2] = '{2, 1};

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [1:0]      valid = '0;
  logic [1:0][7:0] data = '0;
  logic [1:0]      dcx_in = '0;
  logic [1:0]      last_in = '0;

  logic [1:0] rdy_a, gr_a, rdy_b, gr_b;
  logic       wr_a, dcx_a, busy_a, boot_a, wr_b, dcx_b, busy_b, boot_b;
  logic [7:0] d_a, d_b;

  logic [1:0] o_rdy [2];
  logic [1:0] o_gr [2];
  logic       o_wr [2];
  logic       o_dcx [2];
  logic       o_busy [2];
  logic       o_boot [2];
  logic [7:0] o_d [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit started = 0;
  logic [1:0] acc_seen = '0;
  int acc1_q [$];

  // model: cycles of boot left, cycles of the byte period left, owner (-1 none)
  int         boot_left [2];
  int         strobe_left [2];
  int         owner [2];
  bit         locked [2];
  bit         lastf [2];
  bit         m_dcx [2];
  logic [7:0] m_d [2];

  always #5 clk = ~clk;

  lcd_bus_scheduler #(.WR_LOW(2), .WR_HIGH(2), .BOOT_WAIT(BW)) dut0 (
    .clk(clk), .nrst(nrst),
    .req0_valid(valid[0]), .req0_data(data[0]), .req0_dcx(dcx_in[0]), .req0_last(last_in[0]),
    .req0_ready(rdy_a[0]),
    .req1_valid(valid[1]), .req1_data(data[1]), .req1_dcx(dcx_in[1]), .req1_last(last_in[1]),
    .req1_ready(rdy_a[1]),
    .wr(wr_a), .dcx(dcx_a), .D(d_a), .grant(gr_a), .busy(busy_a), .boot_done(boot_a));

  lcd_bus_scheduler #(.WR_LOW(1), .WR_HIGH(1), .BOOT_WAIT(BW)) dut1 (
    .clk(clk), .nrst(nrst),
    .req0_valid(valid[0]), .req0_data(data[0]), .req0_dcx(dcx_in[0]), .req0_last(last_in[0]),
    .req0_ready(rdy_b[0]),
    .req1_valid(valid[1]), .req1_data(data[1]), .req1_dcx(dcx_in[1]), .req1_last(last_in[1]),
    .req1_ready(rdy_b[1]),
    .wr(wr_b), .dcx(dcx_b), .D(d_b), .grant(gr_b), .busy(busy_b), .boot_done(boot_b));

  always_comb begin
    o_rdy[0] = rdy_a;  o_rdy[1] = rdy_b;
    o_gr[0] = gr_a;    o_gr[1] = gr_b;
    o_wr[0] = wr_a;    o_wr[1] = wr_b;
    o_dcx[0] = dcx_a;  o_dcx[1] = dcx_b;
    o_busy[0] = busy_a; o_busy[1] = busy_b;
    o_boot[0] = boot_a; o_boot[1] = boot_b;
    o_d[0] = d_a;      o_d[1] = d_b;
  end

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[%0d] @cyc %0d: got %0h, want %0h", nm, idx, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: no accept within 200 cycles, want an accept", nm);
  endtask

  function automatic logic exp_ready(input int i, input int p);
    if (boot_left[i] != 0 || strobe_left[i] != 0) return 1'b0;
    if (locked[i]) return (owner[i] == p) && valid[p];
    return (p == 0) ? valid[0] : (valid[1] && !valid[0]);
  endfunction

  task automatic m_reset(input int i);
    boot_left[i] = BW;
    strobe_left[i] = 0;
    owner[i] = -1;
    locked[i] = 0;
    lastf[i] = 0;
    m_dcx[i] = 1;
    m_d[i] = 8'h00;
  endtask

  initial for (int i = 0; i < 2; i++) m_reset(i);

  always @(posedge clk) begin
    started = 1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!nrst) m_reset(i);
      else if (boot_left[i] > 0) boot_left[i]--;
      else if (strobe_left[i] > 0) begin
        strobe_left[i]--;
        if (strobe_left[i] == 0 && lastf[i]) owner[i] = -1;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (exp_ready(i, p)) begin
            m_d[i] = data[p];
            m_dcx[i] = dcx_in[p];
            lastf[i] = last_in[p];
            locked[i] = !last_in[p];
            owner[i] = p;
            strobe_left[i] = wl[i] + wh[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("ready", i, o_rdy[i], {exp_ready(i, 1), exp_ready(i, 0)});
        chk("wr", i, o_wr[i], !(strobe_left[i] > wh[i]));
        chk("D", i, o_d[i], m_d[i]);
        chk("dcx", i, o_dcx[i], m_dcx[i]);
        chk("grant", i, o_gr[i], (owner[i] < 0) ? 0 : (1 << owner[i]));
        chk("busy", i, o_busy[i], (boot_left[i] != 0) || (strobe_left[i] != 0) || locked[i]);
        chk("boot_done", i, o_boot[i], boot_left[i] == 0);
      end
      acc_seen = o_rdy[0] & {2{nrst}};
      for (int p = 0; p < 2; p++)
        if (acc_seen[p])
          $display("txn dut0 port%0d D=%02h dcx=%0d last=%0d cyc=%0d",
                   p, data[p], dcx_in[p], last_in[p], cyc);
      if (o_rdy[1][0] && nrst) acc1_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int p, output int t);
    int n = 0;
    forever begin
      @(negedge clk);
      if (o_rdy[0][p] && nrst) break;
      n++;
      if (n >= 200) begin bound_fail("wait_rdy"); break; end
    end
    t = cyc;
    tick();
  endtask

  task automatic send(input int p, input logic [7:0] d, input logic c, input logic l, output int t);
    valid[p] = 1'b1;
    data[p] = d;
    dcx_in[p] = c;
    last_in[p] = l;
    wait_rdy(p, t);
  endtask

  // Counts cycles since release until port 0 is first accepted; port 0 must be valid.
  task automatic boot_check(input int start);
    int n = start;
    forever begin
      @(negedge clk);
      if (n == BW - 1) chk("boot_done_early", 0, o_boot[0], 0);
      if (o_rdy[0][0]) break;
      n++;
      if (n >= 200) begin bound_fail("boot"); break; end
    end
    chk("boot_first_ready", 0, n, BW);
    chk("boot_done_set", 0, o_boot[0], 1);
    tick();
    valid[0] = 1'b0;
  endtask

  task automatic new_byte(input int p);
    valid[p] = 1'b1;
    data[p] = 8'($urandom);
    dcx_in[p] = 1'($urandom_range(1));
    last_in[p] = ($urandom_range(2) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, t1, t2, t3, t4;
    int s [4];

    // boot with port 0 already requesting
    valid[0] = 1; data[0] = 8'h11; dcx_in[0] = 0; last_in[0] = 1;
    repeat (3) @(posedge clk);
    #1 nrst = 1;
    boot_check(0);
    repeat (8) tick();

    // single byte from port 1
    send(1, 8'hA5, 1'b1, 1'b1, t);
    valid[1] = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_wr", k, o_wr[0], k >= 2);
      chk("t2_D", k, o_d[0], 8'hA5);
      chk("t2_dcx", k, o_dcx[0], 1);
      chk("t2_grant", k, o_gr[0], 2);
    end
    @(negedge clk);
    chk("t2_grant_end", 0, o_gr[0], 0);
    chk("t2_busy_end", 0, o_busy[0], 0);
    tick();

    // priority: both valid, port 0 wins, port 1 follows one byte period later
    valid[1] = 1; data[1] = 8'h77; dcx_in[1] = 1; last_in[1] = 1;
    send(0, 8'h3C, 1'b0, 1'b1, t0);
    valid[0] = 0;
    @(negedge clk);
    chk("t3_grant", 0, o_gr[0], 1);
    chk("t3_r1_blocked", 0, o_rdy[0][1], 0);
    tick();
    send(1, 8'h77, 1'b1, 1'b1, t1);
    valid[1] = 0;
    chk("t3_next_accept", 0, t1 - t0, 5);

    // lock: port 1 keeps the bus for three bytes even though port 0 waits
    repeat (6) tick();
    send(1, 8'hB1, 1'b1, 1'b0, t1);
    valid[0] = 1; data[0] = 8'hC0; dcx_in[0] = 0; last_in[0] = 1;
    send(1, 8'hB2, 1'b1, 1'b0, t2);
    send(1, 8'hB3, 1'b1, 1'b1, t3);
    valid[1] = 0;
    wait_rdy(0, t4);
    valid[0] = 0;
    chk("t4_b2", 0, t2 - t1, 5);
    chk("t4_b3", 0, t3 - t1, 10);
    chk("t4_req0", 0, t4 - t3, 5);
    @(negedge clk);
    chk("t4_grant", 0, o_gr[0], 1);
    tick();

    // throughput: 5-cycle period on dut0, 3-cycle period on dut1
    repeat (6) tick();
    acc1_q.delete();
    for (int k = 0; k < 4; k++) send(0, 8'(k + 1), 1'b1, 1'b1, s[k]);
    valid[0] = 0;
    for (int k = 1; k < 4; k++) chk("t5_period", k, s[k] - s[k-1], 5);
    chk("t5_fast_count", 0, acc1_q.size(), 6);
    for (int k = 1; k < acc1_q.size(); k++) chk("t5_fast_period", k, acc1_q[k] - acc1_q[k-1], 3);

    // reset in the middle of the low phase
    repeat (6) tick();
    send(0, 8'h5A, 1'b1, 1'b0, t);
    last_in[0] = 1;
    nrst = 0;
    @(negedge clk);
    chk("t6_wr_before", 0, o_wr[0], 0);
    tick();
    nrst = 1;
    @(negedge clk);
    chk("t6_wr", 0, o_wr[0], 1);
    chk("t6_grant", 0, o_gr[0], 0);
    chk("t6_boot_done", 0, o_boot[0], 0);
    chk("t6_busy", 0, o_busy[0], 1);
    boot_check(1);
    repeat (6) tick();

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (valid[p] && acc_seen[p]) begin
          if ($urandom_range(9) < 7) new_byte(p);
          else valid[p] = 0;
        end else if (!valid[p]) begin
          if ($urandom_range(3) == 0) new_byte(p);
        end else if ($urandom_range(15) == 0) begin
          if ($urandom_range(1) == 1) valid[p] = 0;
          else new_byte(p);
        end
      end
      nrst = ($urandom_range(699) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
